ps2_rx: RTL and testbench
=========================

# ps2_rx

PS/2 device-to-host receiver. It synchronises the raw PS/2 clock and data lines into the system clock domain and deframes each 11-bit frame: start, 8 data bits LSB-first, odd parity, stop. Each good byte is presented with a one-cycle strobe. It sits directly upstream of the keydown scan-code stage: `o_byte`/`o_byte_en` connect to that stage's `i_byte`/`i_byte_en`.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages in each input synchroniser; minimum 2.
- `TIMEOUT_CYCLES`, 50000: `clk` cycles allowed between consecutive PS/2 falling edges inside a frame.
- `TIMEOUT_W`, 16: width of the timeout counter; must hold `TIMEOUT_CYCLES`.

Ports:
- `clk` in 1: system clock.
- `i_sclr` in 1: reset, asynchronous, active-high.
- `i_ps2_clk` in 1: raw PS/2 clock line, asynchronous.
- `i_ps2_data` in 1: raw PS/2 data line, asynchronous.
- `o_byte` out 8: last good received byte; holds until the next good byte.
- `o_byte_en` out 1: one-cycle strobe, `o_byte` updated this cycle.
- `o_frame_err` out 1: one-cycle strobe on a start/parity/stop error or a timeout.

## Operation
- Both inputs pass through identical `SYNC_STAGES` synchronisers, so the synchronised clock and data stay aligned.
- A falling-edge detector compares the synchronised clock with a one-cycle-delayed copy. Its output, `fall`, is 1 when prev=1 and cur=0. All frame sampling happens only on `fall`, using the synchronised data.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), clear the bit counter and go to DATA. On `fall` with data=1, discard the edge and stay in IDLE with no error.
  - DATA: on `fall`, shift right, inserting the new bit at bit 7, and increment the 3-bit counter. After the 8th bit (counter wraps 7→0), go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, the frame is good if data=1 and parity is good. Good frame: load `o_byte` from the shift register and pulse `o_byte_en`. Bad frame: pulse `o_frame_err` and leave `o_byte` unchanged. Either way, return to IDLE.
- Parity is good when the XOR of the 8 data bits and the parity bit equals 1 (odd parity).
- Timeout:
  - In any non-IDLE state, the counter increments each `clk` and clears on each `fall`.
  - When it reaches `TIMEOUT_CYCLES-1`, the FSM returns to IDLE and `o_frame_err` pulses.
  - The counter is held at 0 in IDLE.
- If a timeout and a `fall` occur in the same cycle, `fall` wins: it is processed normally and the counter clears.
- `o_byte_en` and `o_frame_err` are never asserted in the same cycle.

## Timing
- Reset values: `o_byte`=8'h00, `o_byte_en`=0, `o_frame_err`=0, FSM=IDLE, counters=0, synchroniser and edge-detect flops=1 (line idle-high).
- Asserting `i_sclr` mid-frame aborts the frame immediately, with no strobe. After release, the first falling edge is treated as a candidate start bit.
- Latency: edge E is the first rising `clk` edge that samples `i_ps2_clk`=0 for the stop bit. `o_byte_en` is high for exactly one cycle, starting `SYNC_STAGES+2` edges after E. `o_byte` is valid in that same cycle.
- `o_frame_err` has the same latency relative to the stop-bit edge. For a timeout, it asserts one cycle after the counter reaches `TIMEOUT_CYCLES-1`.
- There is no backpressure. A downstream stage must accept one byte per strobe. The minimum strobe spacing is one PS/2 frame.

## Configuration
- Macro: `PS2_RX_PARITY_CHECK_EN`.
- Defined: a parity mismatch makes the frame bad, so `o_frame_err` pulses and no byte is delivered.
- Undefined: the parity bit is sampled and ignored. Only a bad stop bit or a timeout raises `o_frame_err`.

## Test plan
- Reset then a valid frame for 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) → `o_byte`=0x1C, `o_byte_en` high 1 cycle, `o_frame_err`=0.
- Back-to-back frames 0xF0 (parity 1) then 0x1C → two single-cycle strobes carrying 0xF0 then 0x1C, with `o_byte` holding 0xF0 between them.
- Frame 0x1C with parity=1:
  - With the macro → `o_frame_err` pulses and `o_byte` stays at its prior value.
  - Without the macro → `o_byte`=0x1C with a strobe.
- Frame 0x29 with stop=0 → `o_frame_err` pulses once, with no `o_byte_en`.
- Start bit plus 4 data bits, then the clock held high for more than `TIMEOUT_CYCLES` → `o_frame_err` pulses once. A following valid 0x29 frame then yields `o_byte`=0x29.
- `i_sclr` pulsed after 5 bits of a frame → all outputs return to reset values immediately. A following valid 0x1C frame decodes correctly.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises raw clock/data, deframes 11-bit frames, strobes good bytes.
// Latency: o_byte_en/o_frame_err rise SYNC_STAGES+2 clk edges after the first edge sampling the stop-bit low clock.
// Backpressure: none; downstream must take every strobe (at most one byte per PS/2 frame). Option: PS2_RX_PARITY_CHECK_EN.
module ps2_rx #(
   parameter int SYNC_STAGES    = 2,      // flops per input synchroniser, minimum 2
   parameter int TIMEOUT_CYCLES = 50000,  // clk cycles allowed between PS/2 falling edges mid-frame
   parameter int TIMEOUT_W      = 16      // must hold TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       i_sclr,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic [7:0] o_byte,
   output logic       o_byte_en,
   output logic       o_frame_err
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   cur_clk;
   logic                   prev_clk;
   logic                   cur_data;
   logic                   fall;
   logic                   fall_q;
   logic                   bit_q;

   state_t                 state;
   logic [7:0]             shreg;
   logic [2:0]             bit_cnt;
   logic [TIMEOUT_W-1:0]   tcnt;
   logic                   frame_good;

`ifdef PS2_RX_PARITY_CHECK_EN
   logic                   par_bit;
   logic                   parity_ok;
`endif

   // Identical synchronisers on clock and data keep the two lines aligned; idle-high reset.
   always_ff @(posedge clk or posedge i_sclr) begin
      if (i_sclr) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], i_ps2_data};
      end
   end

   // Edge-detect flops: current/previous synchronised clock plus data kept in step with cur_clk.
   always_ff @(posedge clk or posedge i_sclr) begin
      if (i_sclr) begin
         cur_clk  <= 1'b1;
         prev_clk <= 1'b1;
         cur_data <= 1'b1;
      end else begin
         cur_clk  <= clk_sync[SYNC_STAGES-1];
         prev_clk <= cur_clk;
         cur_data <= data_sync[SYNC_STAGES-1];
      end
   end

   assign fall = prev_clk & ~cur_clk;

   // Register the falling-edge pulse with its data bit so the FSM sees a clean, aligned sample.
   always_ff @(posedge clk or posedge i_sclr) begin
      if (i_sclr) begin
         fall_q <= 1'b0;
         bit_q  <= 1'b1;
      end else begin
         fall_q <= fall;
         bit_q  <= cur_data;
      end
   end

`ifdef PS2_RX_PARITY_CHECK_EN
   assign parity_ok  = ^{shreg, par_bit};
   assign frame_good = bit_q & parity_ok;
`else
   assign frame_good = bit_q;
`endif

   // Frame FSM with timeout; a falling edge always takes priority over an expiring timeout.
   always_ff @(posedge clk or posedge i_sclr) begin
      if (i_sclr) begin
         state       <= IDLE;
         shreg       <= 8'h00;
         bit_cnt     <= 3'd0;
         tcnt        <= '0;
         o_byte      <= 8'h00;
         o_byte_en   <= 1'b0;
         o_frame_err <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
         par_bit     <= 1'b0;
`endif
      end else begin
         o_byte_en   <= 1'b0;
         o_frame_err <= 1'b0;
         if (fall_q) begin
            tcnt <= '0;
            case (state)
               IDLE: begin
                  // A high data bit here is a stray edge, not a start bit.
                  if (!bit_q) begin
                     bit_cnt <= 3'd0;
                     state   <= DATA;
                  end
               end
               DATA: begin
                  shreg   <= {bit_q, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
                  par_bit <= bit_q;
`endif
                  state <= STOP;
               end
               STOP: begin
                  if (frame_good) begin
                     o_byte    <= shreg;
                     o_byte_en <= 1'b1;
                  end else begin
                     o_frame_err <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (tcnt == TIMEOUT_LAST) begin
               tcnt        <= '0;
               state       <= IDLE;
               o_frame_err <= 1'b1;
            end else begin
               tcnt <= tcnt + TIMEOUT_W'(1);
            end
         end else begin
            tcnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good frames, stray edge, parity/stop errors, timeout, mid-frame reset.
// Latency: checks the stop-bit-to-strobe delay cycle by cycle on the first frame.
// Backpressure: not applicable; strobes are counted by a monitor and compared to expected totals.
module tb_ps2_rx;

   localparam int SYNC_STAGES    = 2;
   localparam int TIMEOUT_CYCLES = 300;
   localparam int TIMEOUT_W      = 16;
   localparam int HALF_BIT       = 10;

   logic       clk;
   logic       i_sclr;
   logic       i_ps2_clk;
   logic       i_ps2_data;
   logic [7:0] o_byte;
   logic       o_byte_en;
   logic       o_frame_err;

   int checks = 0;
   int errors = 0;
   int en_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int exp_en = 0;
   int exp_err = 0;

   ps2_rx #(
      .SYNC_STAGES   (SYNC_STAGES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TIMEOUT_W     (TIMEOUT_W)
   ) dut (
      .clk        (clk),
      .i_sclr     (i_sclr),
      .i_ps2_clk  (i_ps2_clk),
      .i_ps2_data (i_ps2_data),
      .o_byte     (o_byte),
      .o_byte_en  (o_byte_en),
      .o_frame_err(o_frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count strobes on the falling clk edge, away from the active edge.
   always @(negedge clk) begin
      if (o_byte_en) en_cnt++;
      if (o_frame_err) err_cnt++;
      if (o_byte_en && o_frame_err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      i_ps2_data = b;
      repeat (HALF_BIT) @(negedge clk);
      i_ps2_clk = 1'b0;
      repeat (HALF_BIT) @(negedge clk);
      i_ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(p);
      send_bit(s);
      repeat (8) @(negedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] b1c;
      b1c = 8'h1C;
      i_sclr     = 1'b1;
      i_ps2_clk  = 1'b1;
      i_ps2_data = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_byte", 32'(o_byte), 32'h00);
      check("reset_en", 32'(o_byte_en), 32'd0);
      check("reset_err", 32'(o_frame_err), 32'd0);
      i_sclr = 1'b0;
      repeat (5) @(negedge clk);

      // 0x1C with cycle-accurate latency check on the stop bit.
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b1c[i]);
      send_bit(1'b0);
      @(negedge clk);
      i_ps2_data = 1'b1;
      repeat (HALF_BIT) @(negedge clk);
      i_ps2_clk = 1'b0;
      @(posedge clk);  // edge E
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("lat_en_E+%0d", k), 32'(o_byte_en), (k == SYNC_STAGES + 2) ? 32'd1 : 32'd0);
         if (k == SYNC_STAGES + 2) begin
            check("lat_byte", 32'(o_byte), 32'h1C);
            check("lat_err", 32'(o_frame_err), 32'd0);
         end
      end
      @(negedge clk);
      i_ps2_clk = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      exp_en++;
      check("f1c_en_cnt", 32'(en_cnt), 32'(exp_en));
      check("f1c_err_cnt", 32'(err_cnt), 32'(exp_err));

      // Stray falling edge with data high in IDLE: ignored, no error.
      send_bit(1'b1);
      repeat (8) @(negedge clk);
      #1;
      check("stray_err_cnt", 32'(err_cnt), 32'(exp_err));
      check("stray_en_cnt", 32'(en_cnt), 32'(exp_en));

      // Back-to-back 0xF0 then 0x1C.
      send_frame(8'hF0, 1'b1, 1'b1);
      exp_en++;
      check("bb_f0_byte", 32'(o_byte), 32'hF0);
      check("bb_f0_en_cnt", 32'(en_cnt), 32'(exp_en));
      send_frame(8'h1C, 1'b0, 1'b1);
      exp_en++;
      check("bb_1c_byte", 32'(o_byte), 32'h1C);
      check("bb_1c_en_cnt", 32'(en_cnt), 32'(exp_en));

      // Good 0x29 so a bad-parity 0x1C is distinguishable.
      send_frame(8'h29, 1'b0, 1'b1);
      exp_en++;
      check("g29_byte", 32'(o_byte), 32'h29);
      send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_RX_PARITY_CHECK_EN
      exp_err++;
      check("par_byte", 32'(o_byte), 32'h29);
`else
      exp_en++;
      check("par_byte", 32'(o_byte), 32'h1C);
`endif
      check("par_en_cnt", 32'(en_cnt), 32'(exp_en));
      check("par_err_cnt", 32'(err_cnt), 32'(exp_err));

      // 0x29 with a bad stop bit.
      send_frame(8'h29, 1'b0, 1'b0);
      exp_err++;
      check("stop_en_cnt", 32'(en_cnt), 32'(exp_en));
      check("stop_err_cnt", 32'(err_cnt), 32'(exp_err));

      // Start + 4 data bits then the clock idles past the timeout.
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      repeat (TIMEOUT_CYCLES + 100) @(negedge clk);
      #1;
      exp_err++;
      check("to_err_cnt", 32'(err_cnt), 32'(exp_err));
      check("to_en_cnt", 32'(en_cnt), 32'(exp_en));
      send_frame(8'h29, 1'b0, 1'b1);
      exp_en++;
      check("to_next_byte", 32'(o_byte), 32'h29);
      check("to_next_en_cnt", 32'(en_cnt), 32'(exp_en));

      // Reset pulsed after 5 bits of a frame, off the clock edge.
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      #3;
      i_sclr = 1'b1;
      #1;
      check("sclr_byte", 32'(o_byte), 32'h00);
      check("sclr_en", 32'(o_byte_en), 32'd0);
      check("sclr_err", 32'(o_frame_err), 32'd0);
      repeat (2) @(negedge clk);
      i_sclr = 1'b0;
      repeat (4) @(negedge clk);
      send_frame(8'h1C, 1'b0, 1'b1);
      exp_en++;
      check("sclr_next_byte", 32'(o_byte), 32'h1C);
      check("sclr_next_en_cnt", 32'(en_cnt), 32'(exp_en));
      check("sclr_next_err_cnt", 32'(err_cnt), 32'(exp_err));

      check("never_both", 32'(both_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
